spart_ctrl: RTL and testbench

Control and bus-interface block for the SPART serial port. It owns the 16-bit baud divisor and generates the per-bit `rx_baud` tick for the receive datapath, aligned to mid-bit after each start edge, plus a free-running `tx_baud` for the transmitter. It decodes the 2-bit CPU I/O bus into data, status and divisor accesses, issues read-acknowledge and load strobes, and tracks overrun and dropped-write conditions.

---
 rtl/spart_pkg.sv | 25 ++
 rtl/spart_baud_div.sv | 41 ++++
 rtl/spart_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_spart_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART control block.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DB_LO  = 2'b10,
    ADDR_DB_HI  = 2'b11
  } ioaddr_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BUSY,
    RX_DONE
  } rx_state_t;

  localparam int STAT_TBR  = 0;
  localparam int STAT_RDA  = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_DROP = 3;

  localparam logic [15:0] DB_RESET_DEFAULT = 16'd5208;
  localparam logic [15:0] MIN_DB_DEFAULT   = 16'd16;

endpackage

// File: rtl/spart_baud_div.sv
// Reloadable 16-bit down-counter: ticks when the count reaches 1, then
// reloads from reload_value so a new period only applies at the next reload.
module spart_baud_div #(
  parameter logic [15:0] RESET_VAL = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic [15:0] reload_value,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = en && (cnt_q == 16'd1);

  // Next count: explicit load wins, then reload on tick, else count down.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (tick) begin
      cnt_d = reload_value;
    end else if (en) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spart_ctrl.sv
// SPART control: baud generation, RX tick sequencing and CPU bus decode.
module spart_ctrl
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = DB_RESET_DEFAULT,
  parameter logic [15:0] MIN_DB   = MIN_DB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  input  logic       rxd,
  input  logic       rda,
  input  logic [7:0] rx_data,
  output logic       rx_baud,
  output logic       rx_read_en,
  input  logic       tbr,
  output logic       tx_baud,
  output logic       tx_load,
  output logic [7:0] tx_data
);

  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        rx_sync;
  rx_state_t   rx_state_q, rx_state_d;
  logic [3:0]  rx_bits_q, rx_bits_d;
  logic [15:0] db_q, db_d;
  logic [7:0]  db_lo_q, db_lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_load_q, tx_load_d;
  logic        ovr_q, ovr_d;
  logic        drop_q, drop_d;

  ioaddr_t     addr;
  logic        bus_rd, bus_wr, stat_rd;
  logic        rx_en, rx_load, rx_tick;
  logic [15:0] db_half, db_commit;
  logic [7:0]  status;

  assign addr       = ioaddr_t'(ioaddr);
  assign bus_rd     = iocs & iorw;
  assign bus_wr     = iocs & ~iorw;
  assign rx_read_en = bus_rd && (addr == ADDR_DATA);
  assign stat_rd    = bus_rd && (addr == ADDR_STATUS);
  assign rx_sync    = sync2_q;
  assign rx_en      = (rx_state_q == RX_BUSY);
  assign rx_load    = (rx_state_q == RX_IDLE) && !rx_sync;
  assign db_half    = {1'b0, db_q[15:1]};
  assign db_commit  = {bus_wdata, db_lo_q};
  assign rx_baud    = rx_tick;
  assign tx_load    = tx_load_q;
  assign tx_data    = tx_data_q;

  spart_baud_div #(.RESET_VAL(DB_RESET)) u_tx_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (1'b1),
    .load         (1'b0),
    .load_value   (db_q),
    .reload_value (db_q),
    .tick         (tx_baud)
  );

  spart_baud_div #(.RESET_VAL(16'd0)) u_rx_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (rx_en),
    .load         (rx_load),
    .load_value   (db_half),
    .reload_value (db_q),
    .tick         (rx_tick)
  );

  // Two-stage rxd synchronizer, idle-high like the receiver's own.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
  end

  // RX sequencer: half-bit delay to mid start bit, then ten ticks, one done cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bits_d  = rx_bits_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_d = RX_BUSY;
          rx_bits_d  = 4'd0;
        end
      end
      RX_BUSY: begin
        if (rx_tick) begin
          if (rx_bits_q == 4'd9) begin
            rx_state_d = RX_DONE;
          end else begin
            rx_bits_d = rx_bits_q + 4'd1;
          end
        end
      end
      RX_DONE: rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Bus writes and sticky flags; a set in the same cycle as a status-read clear wins.
  always_comb begin
    db_d      = db_q;
    db_lo_d   = db_lo_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    ovr_d     = ovr_q;
    drop_d    = drop_q;
    if (stat_rd) begin
      ovr_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (bus_wr) begin
      case (addr)
        ADDR_DATA: begin
          if (tbr) begin
            tx_data_d = bus_wdata;
            tx_load_d = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
        ADDR_DB_LO: db_lo_d = bus_wdata;
        ADDR_DB_HI: db_d = (db_commit < MIN_DB) ? MIN_DB : db_commit;
        default: ;
      endcase
    end
    if ((rx_state_q == RX_DONE) && rda && !rx_read_en) begin
      ovr_d = 1'b1;
    end
  end

  // Combinational read mux; idle bus reads as zero.
  always_comb begin
    status            = 8'h00;
    status[STAT_TBR]  = tbr;
    status[STAT_RDA]  = rda;
    status[STAT_OVR]  = ovr_q;
    status[STAT_DROP] = drop_q;
    bus_rdata         = 8'h00;
    if (bus_rd) begin
      case (addr)
        ADDR_DATA:   bus_rdata = rx_data;
        ADDR_STATUS: bus_rdata = status;
        ADDR_DB_LO:  bus_rdata = db_q[7:0];
        ADDR_DB_HI:  bus_rdata = db_q[15:8];
        default:     bus_rdata = 8'h00;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_bits_q  <= 4'd0;
      db_q       <= DB_RESET;
      db_lo_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_load_q  <= 1'b0;
      ovr_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_state_q <= rx_state_d;
      rx_bits_q  <= rx_bits_d;
      db_q       <= db_d;
      db_lo_q    <= db_lo_d;
      tx_data_q  <= tx_data_d;
      tx_load_q  <= tx_load_d;
      ovr_q      <= ovr_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_spart_ctrl.sv
// Testbench for spart_ctrl: drives serial frames and bus accesses, and acts
// as the receiver, decoding the line at each rx_baud tick.
module tb_spart_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic       rxd = 1'b1;
  logic       rda = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_baud;
  logic       rx_read_en;
  logic       tbr = 1'b1;
  logic       tx_baud;
  logic       tx_load;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spart_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .rxd        (rxd),
    .rda        (rda),
    .rx_data    (rx_data),
    .rx_baud    (rx_baud),
    .rx_read_en (rx_read_en),
    .tbr        (tbr),
    .tx_baud    (tx_baud),
    .tx_load    (tx_load),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  // Cycle number: during the cycle after posedge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor.
  int tick_q[$];
  int rd_en_cnt = 0;
  int tx_load_cnt = 0;
  int tx_cnt = 0;
  int tx_last = 0;
  int tx_gap = 0;
  initial forever begin
    @(negedge clk);
    if (rx_baud) tick_q.push_back(cyc);
    if (rx_read_en) rd_en_cnt++;
    if (tx_load) tx_load_cnt++;
    if (tx_baud) begin
      tx_gap = cyc - tx_last;
      tx_last = cyc;
      tx_cnt++;
    end
  end

  // Receiver model: its own line synchronizer, samples at each tick.
  logic s1 = 1'b1;
  logic s2 = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
    end
  end

  int         rcv_idx = 0;
  logic [7:0] rcv_byte = 8'h00;
  bit         frame_ok = 1'b1;
  bit         pend = 1'b0;
  bit         pend2 = 1'b0;
  logic [7:0] got_q[$];
  bit         ok_q[$];
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rcv_idx = 0;
      pend = 1'b0;
      pend2 = 1'b0;
      rda = 1'b0;
      rx_data = 8'h00;
    end else begin
      if (rx_read_en) rda = 1'b0;
      if (pend2) begin
        rda = 1'b1;
        rx_data = rcv_byte;
        pend2 = 1'b0;
      end
      if (pend) begin
        pend2 = 1'b1;
        pend = 1'b0;
      end
      if (rx_baud) begin
        if (rcv_idx == 0) frame_ok = (s2 == 1'b0);
        else if (rcv_idx <= 8) rcv_byte[rcv_idx-1] = s2;
        else frame_ok = frame_ok && (s2 == 1'b1);
        if (rcv_idx == 9) begin
          got_q.push_back(rcv_byte);
          ok_q.push_back(frame_ok);
          rcv_idx = 0;
          pend = 1'b1;
        end else begin
          rcv_idx++;
        end
      end
    end
  end

  logic [7:0] rd_val;
  logic       rd_en_seen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access cycle; entered and left just after a rising edge.
  task automatic applyStimulus(input bit rw, input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1;
    iorw = rw;
    ioaddr = a;
    bus_wdata = d;
    @(negedge clk);
    rd_val = bus_rdata;
    rd_en_seen = rx_read_en;
    @(posedge clk);
    #1;
    iocs = 1'b0;
    iorw = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] b, input int bitlen);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rxd = bits[j];
      repeat (bitlen) @(posedge clk);
      #1;
    end
  endtask

  // Line falls in cycle k, seen synchronized at k+2; ticks at mid-bit from there.
  task automatic checkTicks(input string tag, input int k, input int db, input int base);
    for (int j = 0; j < 10; j++) begin
      int got;
      got = (tick_q.size() > base + j) ? tick_q[base + j] : -1;
      checkOutput($sformatf("%s_tick%0d", tag, j), got, k + 2 + db / 2 + j * db);
    end
  endtask

  task automatic checkFrame(input string tag, input int idx, input logic [7:0] exp);
    checkOutput({tag, "_ok"}, (ok_q.size() > idx) ? ok_q[idx] : 1'b0, 1'b1);
    checkOutput({tag, "_byte"}, (got_q.size() > idx) ? got_q[idx] : 8'hxx, exp);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_bus_rdata"}, bus_rdata, 8'h00);
    checkOutput({tag, "_rx_baud"}, rx_baud, 1'b0);
    checkOutput({tag, "_rx_read_en"}, rx_read_en, 1'b0);
    checkOutput({tag, "_tx_baud"}, tx_baud, 1'b0);
    checkOutput({tag, "_tx_load"}, tx_load, 1'b0);
    checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, k2, base, n, db;
    logic [7:0] b1, b2, b3, b4, lo;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    applyStimulus(1, 2'b10, 8'h00); checkOutput("rst_db_lo", rd_val, 8'h58);
    applyStimulus(1, 2'b11, 8'h00); checkOutput("rst_db_hi", rd_val, 8'h14);

    // Divisor 16; a staged low byte must not show on readback.
    applyStimulus(0, 2'b10, 8'h10);
    applyStimulus(0, 2'b11, 8'h00);
    applyStimulus(0, 2'b10, 8'hEE);
    applyStimulus(1, 2'b10, 8'h00); checkOutput("db16_lo", rd_val, 8'h10);
    applyStimulus(1, 2'b11, 8'h00); checkOutput("db16_hi", rd_val, 8'h00);

    // TX handshake.
    tbr = 1'b1;
    applyStimulus(0, 2'b00, 8'h3C);
    @(negedge clk);
    checkOutput("tx_load_pulse", tx_load, 1'b1);
    checkOutput("tx_data", tx_data, 8'h3C);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("tx_load_single", tx_load, 1'b0);
    @(posedge clk); #1;
    tbr = 1'b0;
    base = tx_load_cnt;
    applyStimulus(0, 2'b00, 8'h77);
    repeat (3) @(posedge clk); #1;
    checkOutput("tx_drop_noload", tx_load_cnt, base);
    checkOutput("tx_drop_data", tx_data, 8'h3C);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("status_drop", rd_val, 8'h08);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("status_drop_clr", rd_val, 8'h00);
    tbr = 1'b1;
    applyStimulus(0, 2'b01, 8'hFF);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("status_wr_ignored", rd_val, 8'h01);

    // Single frame 0xA5 at 16 cycles/bit.
    tick_q.delete(); got_q.delete(); ok_q.delete();
    k = cyc;
    sendFrame(8'hA5, 16);
    repeat (4) @(posedge clk); #1;
    checkOutput("a5_tick_count", tick_q.size(), 10);
    checkTicks("a5", k, 16, 0);
    checkFrame("a5", 0, 8'hA5);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("a5_status", rd_val, 8'h03);
    base = rd_en_cnt;
    applyStimulus(1, 2'b00, 8'h00);
    checkOutput("a5_read", rd_val, 8'hA5);
    checkOutput("a5_read_en", rd_en_seen, 1'b1);
    checkOutput("a5_read_en_count", rd_en_cnt, base + 1);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("a5_status_after", rd_val, 8'h01);

    // Back-to-back frames, neither read: second one overruns.
    b1 = 8'($urandom); b2 = 8'($urandom);
    tick_q.delete(); got_q.delete(); ok_q.delete();
    k = cyc;
    sendFrame(b1, 16);
    k2 = cyc;
    sendFrame(b2, 16);
    repeat (4) @(posedge clk); #1;
    checkOutput("b2b_tick_count", tick_q.size(), 20);
    checkTicks("b2b1", k, 16, 0);
    checkTicks("b2b2", k2, 16, 10);
    checkFrame("b2b1", 0, b1);
    checkFrame("b2b2", 1, b2);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("ovr_status", rd_val, 8'h07);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("ovr_cleared", rd_val, 8'h03);

    // Status read in the very cycle an overrun is set: set wins.
    b3 = 8'($urandom);
    tick_q.delete(); got_q.delete(); ok_q.delete();
    k = cyc;
    fork
      sendFrame(b3, 16);
      begin
        repeat (155) @(posedge clk); #1;
        applyStimulus(1, 2'b01, 8'h00);
      end
    join
    checkOutput("simul_read_value", rd_val, 8'h03);
    repeat (4) @(posedge clk); #1;
    checkFrame("simul", 0, b3);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("simul_set_wins", rd_val, 8'h07);
    applyStimulus(1, 2'b01, 8'h00); checkOutput("simul_cleared", rd_val, 8'h03);
    applyStimulus(1, 2'b00, 8'h00); checkOutput("simul_data", rd_val, b3);

    // Random divisor frame.
    db = $urandom_range(17, 60);
    applyStimulus(0, 2'b10, 8'(db));
    applyStimulus(0, 2'b11, 8'h00);
    applyStimulus(1, 2'b10, 8'h00); checkOutput("rnd_db_lo", rd_val, 8'(db));
    b4 = 8'($urandom);
    tick_q.delete(); got_q.delete(); ok_q.delete();
    k = cyc;
    sendFrame(b4, db);
    repeat (4) @(posedge clk); #1;
    checkOutput("rnd_tick_count", tick_q.size(), 10);
    checkTicks("rnd", k, db, 0);
    checkFrame("rnd", 0, b4);
    applyStimulus(1, 2'b00, 8'h00); checkOutput("rnd_data", rd_val, b4);

    // Clamp of a too-small divisor, and TX period.
    lo = 8'($urandom_range(0, 15));
    applyStimulus(0, 2'b10, lo);
    applyStimulus(0, 2'b11, 8'h00);
    applyStimulus(1, 2'b10, 8'h00); checkOutput("clamp_lo", rd_val, 8'h10);
    applyStimulus(1, 2'b11, 8'h00); checkOutput("clamp_hi", rd_val, 8'h00);
    base = tx_cnt;
    n = 0;
    while (tx_cnt < base + 3 && n < 7000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("tx_wait", (tx_cnt >= base + 3), 1'b1);
    checkOutput("tx_period", tx_gap, 16);

    // Reset in the middle of a frame.
    tick_q.delete();
    rxd = 1'b0;
    repeat (40) @(posedge clk); #1;
    checkOutput("mid_ticks", tick_q.size(), 2);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midrst");
    rxd = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    applyStimulus(1, 2'b10, 8'h00); checkOutput("midrst_db_lo", rd_val, 8'h58);
    applyStimulus(1, 2'b11, 8'h00); checkOutput("midrst_db_hi", rd_val, 8'h14);
    tick_q.delete();
    repeat (40) @(posedge clk); #1;
    checkOutput("midrst_no_ticks", tick_q.size(), 0);

    // Re-arm after reset.
    applyStimulus(0, 2'b10, 8'h10);
    applyStimulus(0, 2'b11, 8'h00);
    b1 = 8'($urandom);
    tick_q.delete(); got_q.delete(); ok_q.delete();
    k = cyc;
    sendFrame(b1, 16);
    repeat (4) @(posedge clk); #1;
    checkOutput("rearm_tick_count", tick_q.size(), 10);
    checkTicks("rearm", k, 16, 0);
    checkFrame("rearm", 0, b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
